// File: rtl/dds_voice_bank.sv
// dds_voice_bank: round-robin time-multiplexed N-voice DDS synthesiser.
// One phase accumulator and one waveform generator are shared by all voices.
// A frame mixer averages the voice samples of each frame into mix_out.
// Optional hard sync between adjacent voices: define DDS_VOICE_SYNC_EN.
module dds_voice_bank #(
  parameter int VOICES = 4,
  parameter int TUNE_W = 16,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(VOICES)-1:0] wr_addr,
  input  logic [TUNE_W-1:0]         wr_tune,
  input  logic [1:0]                wr_mode,
  input  logic                      wr_ena,
`ifdef DDS_VOICE_SYNC_EN
  input  logic [VOICES-1:0]         sync_mask,
`endif
  output logic [OUT_W-1:0]          mix_out,
  output logic                      out_valid,
  output logic [$clog2(VOICES)-1:0] slot
);

  localparam int SLOT_W = $clog2(VOICES);
  // The frame sum holds VOICES full-scale samples without overflow.
  localparam int SUM_W = OUT_W + SLOT_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(VOICES - 1);

  // Per-voice state.
  logic [ACC_W-1:0]  acc  [VOICES];
  logic [TUNE_W-1:0] tune [VOICES];
  logic [1:0]        mode [VOICES];
  logic [VOICES-1:0] ena;

  // Stage 0: the voice currently selected by the sequencer.
  logic [SLOT_W-1:0] slot_p0;
  logic [OUT_W-1:0]  phase_p0;
  logic [OUT_W-1:0]  sample_p0;
  logic [ACC_W-1:0]  acc_next_p0;
  logic [SUM_W-1:0]  sum_total_p0;

  // Stage 1: frame accumulation and the registered mix output.
  logic [SUM_W-1:0]  sum_p1;
  logic [OUT_W-1:0]  mix_p1;
  logic              vld_p1;

`ifdef DDS_VOICE_SYNC_EN
  logic [ACC_W:0]    acc_sum_p0;
  logic              carry_p0;
  // Carry-out of the previous slot's add; slot 0 overwrites it each frame.
  logic              carry_p1;
`endif

  // Maps the phase word to a sample for the selected waveform.
  function automatic logic [OUT_W-1:0] wave_shape(input logic [1:0]       sel,
                                                  input logic [OUT_W-1:0] p);
    logic [OUT_W-1:0] dbl;
    dbl = {p[OUT_W-2:0], 1'b0};
    case (sel)
      2'd0:    wave_shape = p;
      2'd1:    wave_shape = {OUT_W{p[OUT_W-1]}};
      2'd2:    wave_shape = p[OUT_W-1] ? ~dbl : dbl;
      default: wave_shape = '0;
    endcase
  endfunction

  // Divides the frame total by the voice count; the result always fits OUT_W.
  function automatic logic [OUT_W-1:0] frame_average(input logic [SUM_W-1:0] total);
    frame_average = OUT_W'(total >> SLOT_W);
  endfunction

  // Sample, next phase and running frame total for the voice in this slot.
  always_comb begin
    phase_p0  = acc[slot_p0][ACC_W-1 -: OUT_W];
    sample_p0 = ena[slot_p0] ? wave_shape(mode[slot_p0], phase_p0) : '0;
`ifdef DDS_VOICE_SYNC_EN
    acc_sum_p0  = {1'b0, acc[slot_p0]} + (ACC_W + 1)'(tune[slot_p0]);
    carry_p0    = ena[slot_p0] & acc_sum_p0[ACC_W];
    acc_next_p0 = acc_sum_p0[ACC_W-1:0];
    // Hard sync: restart this voice when its lower neighbour wrapped this frame.
    if ((slot_p0 != '0) && sync_mask[slot_p0] && carry_p1)
      acc_next_p0 = '0;
`else
    acc_next_p0 = acc[slot_p0] + ACC_W'(tune[slot_p0]);
`endif
    // A disabled voice freezes its phase.
    if (!ena[slot_p0])
      acc_next_p0 = acc[slot_p0];
    sum_total_p0 = sum_p1 + SUM_W'(sample_p0);
  end

  // Sequencer, phase update and frame mixer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_p0 <= '0;
      sum_p1  <= '0;
      mix_p1  <= '0;
      vld_p1  <= 1'b0;
      for (int i = 0; i < VOICES; i++)
        acc[i] <= '0;
    end else begin
      slot_p0      <= slot_p0 + SLOT_W'(1);
      acc[slot_p0] <= acc_next_p0;
      sum_p1       <= (slot_p0 == '0) ? SUM_W'(sample_p0) : sum_total_p0;
      vld_p1       <= (slot_p0 == LAST_SLOT);
      if (slot_p0 == LAST_SLOT)
        mix_p1 <= frame_average(sum_total_p0);
    end
  end

`ifdef DDS_VOICE_SYNC_EN
  // Remembers whether the slot just processed wrapped its accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n)
      carry_p1 <= 1'b0;
    else
      carry_p1 <= carry_p0;
  end
`endif

  // Voice register write port; a same-slot write takes effect next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ena <= '0;
      for (int i = 0; i < VOICES; i++) begin
        tune[i] <= '0;
        mode[i] <= '0;
      end
    end else if (wr_en) begin
      tune[wr_addr] <= wr_tune;
      mode[wr_addr] <= wr_mode;
      ena[wr_addr]  <= wr_ena;
    end
  end

  assign mix_out   = mix_p1;
  assign out_valid = vld_p1;
  assign slot      = slot_p0;

endmodule

// File: tb/tb_dds_voice_bank.sv
// tb_dds_voice_bank: directed bench for dds_voice_bank (VOICES=4, TUNE_W=16,
// ACC_W=16, OUT_W=12). Expected frame outputs are queued when a scenario is
// set up and popped as each out_valid pulse arrives.
module tb_dds_voice_bank;

  localparam int VOICES = 4;
  localparam int TUNE_W = 16;
  localparam int ACC_W  = 16;
  localparam int OUT_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [TUNE_W-1:0] wr_tune;
  logic [1:0]        wr_mode;
  logic              wr_ena;
`ifdef DDS_VOICE_SYNC_EN
  logic [VOICES-1:0] sync_mask;
`endif
  logic [OUT_W-1:0]  mix_out;
  logic              out_valid;
  logic [1:0]        slot;

  int errors = 0;
  int checks = 0;

  logic [OUT_W-1:0]  exp_q [$];

  // Per-scenario voice setup, written during the first frame after reset.
  logic              cfg_we   [VOICES];
  logic [TUNE_W-1:0] cfg_tune [VOICES];
  logic [1:0]        cfg_mode [VOICES];

  dds_voice_bank #(
    .VOICES (VOICES),
    .TUNE_W (TUNE_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_tune   (wr_tune),
    .wr_mode   (wr_mode),
    .wr_ena    (wr_ena),
`ifdef DDS_VOICE_SYNC_EN
    .sync_mask (sync_mask),
`endif
    .mix_out   (mix_out),
    .out_valid (out_valid),
    .slot      (slot)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compares the current output against the oldest queued frame value.
  task automatic compare_frame(input string tag);
    logic [OUT_W-1:0] e;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_mix"}, 32'(mix_out), 32'(e));
    end
  endtask

  // Waits (bounded) for the next out_valid pulse and checks it.
  task automatic next_frame(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (out_valid !== 1'b1 && n < 2 * VOICES);
    compare_frame(tag);
  endtask

  task automatic restart();
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int v = 0; v < VOICES; v++) begin
      cfg_we[v]   = 1'b0;
      cfg_tune[v] = '0;
      cfg_mode[v] = '0;
    end
  endtask

  task automatic set_voice(input int v, input logic [TUNE_W-1:0] t, input logic [1:0] m);
    cfg_we[v]   = 1'b1;
    cfg_tune[v] = t;
    cfg_mode[v] = m;
  endtask

  // Writes voice v during the cycle that processes slot v, so every
  // configured voice starts from acc=0 together at the start of frame 1.
  // Frame 0 is therefore silent.
  task automatic config_frame(input string tag);
    for (int v = 0; v < VOICES; v++) begin
      check($sformatf("%s_slot%0d", tag, v), 32'(slot), 32'(v));
      wr_en   = cfg_we[v];
      wr_addr = 2'(v);
      wr_tune = cfg_tune[v];
      wr_mode = cfg_mode[v];
      wr_ena  = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    compare_frame({tag, "_f0"});
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_tune = 16'h1000;
    wr_mode = 2'd0;
    wr_ena  = 1'b1;
`ifdef DDS_VOICE_SYNC_EN
    sync_mask = 4'b0010;
`endif

    // Reset with a write held active: the write must not land.
    repeat (3) tick();
    check("rst_mix", 32'(mix_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    rst_n = 1'b1;
    wr_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("rel_valid_c%0d", c), 32'(out_valid), 32'((c % 4) == 0));
      if ((c % 4) == 0)
        check($sformatf("rel_mix_c%0d", c), 32'(mix_out), 32'd0);
    end

    // Saw on voice 0: each frame steps the average by 0x40, then wraps.
    restart();
    set_voice(0, 16'h1000, 2'd0);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 16; f++)
      exp_q.push_back(12'(f * 'h40));
    exp_q.push_back(12'h000);
    config_frame("saw");
    for (int f = 0; f < 17; f++)
      next_frame($sformatf("saw_f%0d", f + 1));

    // Square on voice 1 at half-rate: alternates silent and full scale.
    restart();
    set_voice(1, 16'h8000, 2'd1);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h3FF);
    end
    config_frame("sq");
    for (int f = 0; f < 6; f++)
      next_frame($sformatf("sq_f%0d", f + 1));

    // Triangle on voice 2 at quarter-rate: samples 0, 800, FFF, 7FF.
    restart();
    set_voice(2, 16'h4000, 2'd2);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h200);
      exp_q.push_back(12'h3FF);
      exp_q.push_back(12'h1FF);
    end
    config_frame("tri");
    for (int f = 0; f < 8; f++)
      next_frame($sformatf("tri_f%0d", f + 1));

    // All four voices identical saw: the average equals one voice's sample.
    restart();
    for (int v = 0; v < VOICES; v++)
      set_voice(v, 16'h1000, 2'd0);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 16; f++)
      exp_q.push_back(12'(f * 'h100));
    exp_q.push_back(12'h000);
    config_frame("all_saw");
    for (int f = 0; f < 17; f++)
      next_frame($sformatf("all_saw_f%0d", f + 1));

    // All four voices full-scale square: maximum frame sum.
    restart();
    for (int v = 0; v < VOICES; v++)
      set_voice(v, 16'h8000, 2'd1);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(12'h000);
      exp_q.push_back(12'hFFF);
    end
    config_frame("all_sq");
    for (int f = 0; f < 4; f++)
      next_frame($sformatf("all_sq_f%0d", f + 1));

    // Write collision: retune voice 0 while slot 0 is being processed.
    restart();
    set_voice(0, 16'h1000, 2'd0);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h040);
    config_frame("col");
    next_frame("col_f1");
    next_frame("col_f2");
    check("col_slot", 32'(slot), 32'd0);
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_tune = 16'h2000;
    wr_mode = 2'd0;
    wr_ena  = 1'b1;
    tick();
    wr_en = 1'b0;
    exp_q.push_back(12'h080);
    exp_q.push_back(12'h0C0);
    exp_q.push_back(12'h140);
    exp_q.push_back(12'h1C0);
    for (int f = 0; f < 4; f++)
      next_frame($sformatf("col_f%0d", f + 3));

`ifdef DDS_VOICE_SYNC_EN
    // Hard sync: voice 1 restarts whenever voice 0 wraps.
    restart();
    set_voice(0, 16'h8000, 2'd0);
    set_voice(1, 16'h1000, 2'd0);
    exp_q.push_back(12'h000);
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h240);
    end
    config_frame("sync");
    for (int f = 0; f < 6; f++)
      next_frame($sformatf("sync_f%0d", f + 1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
